// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: Moore sequencer, NZCV flag register and
// condition evaluation driving a shared-memory, single-ALU datapath.
`timescale 1ns/1ps
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W = 2,
    parameter bit          COND_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           Instr,
    input  logic [3:0]            ALUFlags,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            ImmSrc,
    output logic                  RegWrite,
    output logic [1:0]            RegSrc,
    output logic [3:0]            Flags,
    output logic                  Illegal
);

    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_ORR = 3'd3;
    localparam logic [OP_W-1:0] ALU_EOR = 3'd4;
    localparam logic [OP_W-1:0] ALU_MOV = 3'd5;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t          state, state_n;
    logic            cond_ex;
    logic            cond_pass;
    logic [OP_W-1:0] dp_op, alu_op;
    logic            dp_legal, is_cmp, is_arith;
    logic            pcw_c, memw_c, irw_c, regw_c;

    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit, s_bit;
    logic [3:0] cmd;
    logic       unused_instr;

    assign cond   = Instr[31:28];
    assign op     = Instr[27:26];
    assign i_bit  = Instr[25];
    assign cmd    = Instr[24:21];
    assign s_bit  = Instr[20];
    assign ImmSrc = Instr[27:26];
    assign unused_instr = ^Instr[19:0];

    // Data-processing opcode decode; EOR/MOV exist only with the wide ALU control
    always_comb begin
        dp_op    = ALU_ADD;
        dp_legal = 1'b1;
        is_cmp   = 1'b0;
        is_arith = 1'b0;
        case (cmd)
            4'b0100: begin dp_op = ALU_ADD; is_arith = 1'b1; end
            4'b0010: begin dp_op = ALU_SUB; is_arith = 1'b1; end
            4'b0000: dp_op = ALU_AND;
            4'b1100: dp_op = ALU_ORR;
            4'b1010: begin dp_op = ALU_SUB; is_arith = 1'b1; is_cmp = 1'b1; end
            4'b0001: begin dp_op = ALU_EOR; dp_legal = (ALU_CTRL_W >= 3); end
            4'b1101: begin dp_op = ALU_MOV; dp_legal = (ALU_CTRL_W >= 3); end
            default: dp_legal = 1'b0;
        endcase
    end

    // Condition evaluation against the current flag register
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = Flags[2];
            4'b0001: cond_pass = ~Flags[2];
            4'b0010: cond_pass = Flags[1];
            4'b0011: cond_pass = ~Flags[1];
            4'b0100: cond_pass = Flags[3];
            4'b0101: cond_pass = ~Flags[3];
            4'b0110: cond_pass = Flags[0];
            4'b0111: cond_pass = ~Flags[0];
            4'b1000: cond_pass = Flags[1] & ~Flags[2];
            4'b1001: cond_pass = ~Flags[1] | Flags[2];
            4'b1010: cond_pass = (Flags[3] == Flags[0]);
            4'b1011: cond_pass = (Flags[3] != Flags[0]);
            4'b1100: cond_pass = ~Flags[2] & (Flags[3] == Flags[0]);
            4'b1101: cond_pass = Flags[2] | (Flags[3] != Flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
        if (!COND_EN) cond_pass = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_n;
    end

    // CondEx is captured once per instruction, before any flag write of its own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cond_ex <= 1'b0;
        else if (state == S_DECODE) cond_ex <= cond_pass;
    end

    // NZ always written on update; CV only by arithmetic ops, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Flags <= 4'b0000;
        end else if ((state == S_EXECR || state == S_EXECI) && cond_ex && (s_bit || is_cmp)) begin
            Flags[3:2] <= ALUFlags[3:2];
            if (is_arith) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        state_n   = state;
        pcw_c     = 1'b0;
        memw_c    = 1'b0;
        irw_c     = 1'b0;
        regw_c    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        RegSrc    = 2'b00;
        Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                irw_c     = 1'b1;
                pcw_c     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01: state_n = S_MEMADR;
                    2'b10: state_n = S_BRANCH;
                    2'b00: begin
                        if (!dp_legal) begin
                            Illegal = 1'b1;
                            state_n = S_FETCH;
                        end else begin
                            state_n = i_bit ? S_EXECI : S_EXECR;
                        end
                    end
                    default: begin
                        Illegal = 1'b1;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_n = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw_c    = cond_ex;
                state_n   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                memw_c  = cond_ex;
                RegSrc  = 2'b10;
                state_n = S_FETCH;
            end
            S_EXECR: begin
                alu_op  = dp_op;
                state_n = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = dp_op;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                regw_c  = cond_ex & ~is_cmp;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                RegSrc    = 2'b01;
                pcw_c     = cond_ex;
                state_n   = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign ALUControl = ALU_CTRL_W'(alu_op);

    // Enables are held off for the whole reset assertion, not just after the edge
    assign PCWrite  = pcw_c  & rst_n;
    assign IRWrite  = irw_c  & rst_n;
    assign RegWrite = regw_c & rst_n;
    assign MemWrite = memw_c & rst_n;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle output vectors for
// both ALU control widths, plus reset and extended-opcode sequences.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  alu_flags = 4'h0;

    logic       pcw2, adr2, memw2, irw2, srca2, regw2, ill2;
    logic [1:0] res2, srcb2, imm2, regsrc2, aluc2;
    logic [3:0] flags2;
    logic       pcw3, adr3, memw3, irw3, srca3, regw3, ill3;
    logic [1:0] res3, srcb3, imm3, regsrc3;
    logic [2:0] aluc3;
    logic [3:0] flags3;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control_unit #(.ALU_CTRL_W(2), .COND_EN(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(memw2), .IRWrite(irw2),
        .ResultSrc(res2), .ALUSrcA(srca2), .ALUSrcB(srcb2), .ALUControl(aluc2),
        .ImmSrc(imm2), .RegWrite(regw2), .RegSrc(regsrc2), .Flags(flags2),
        .Illegal(ill2)
    );

    multicycle_control_unit #(.ALU_CTRL_W(3), .COND_EN(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(pcw3), .AdrSrc(adr3), .MemWrite(memw3), .IRWrite(irw3),
        .ResultSrc(res3), .ALUSrcA(srca3), .ALUSrcB(srcb3), .ALUControl(aluc3),
        .ImmSrc(imm3), .RegWrite(regw3), .RegSrc(regsrc3), .Flags(flags3),
        .Illegal(ill3)
    );

    always #5 clk = ~clk;

    // Vector layout: pcw adr memw irw res[2] srca srcb[2] aluc[3] regw regsrc[2] flags[4] ill
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  af;
        logic [19:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t vecs3[$];

    function automatic logic [19:0] act2();
        return {pcw2, adr2, memw2, irw2, res2, srca2, srcb2, {1'b0, aluc2},
                regw2, regsrc2, flags2, ill2};
    endfunction

    function automatic logic [19:0] act3();
        return {pcw3, adr3, memw3, irw3, res3, srca3, srcb3, aluc3,
                regw3, regsrc3, flags3, ill3};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] i, input logic [3:0] af, input logic [19:0] e, input string n);
        vec_t v;
        v.instr = i; v.af = af; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic add3(input logic [31:0] i, input logic [3:0] af, input logic [19:0] e, input string n);
        vec_t v;
        v.instr = i; v.af = af; v.exp = e; v.name = n;
        vecs3.push_back(v);
    endtask

    // Called at a negedge: drive, settle, compare, then advance one cycle
    task automatic step_row(input vec_t v, input bit use3);
        instr     = v.instr;
        alu_flags = v.af;
        #1;
        check(v.name, use3 ? act3() : act2(), v.exp);
        @(negedge clk);
    endtask

    localparam logic [19:0] RST_VEC = 20'b0_0_0_0_10_1_10_000_0_00_0000_0;

    initial begin
        // ADD R2,R1,R2: no S, flags untouched even with ALUFlags noise
        add(32'hE0812002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0000_0, "add_fetch");
        add(32'hE0812002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0000_0, "add_decode");
        add(32'hE0812002, 4'b1111, 20'b0_0_0_0_00_0_00_000_0_00_0000_0, "add_execr");
        add(32'hE0812002, 4'b1010, 20'b0_0_0_0_00_0_00_000_1_00_0000_0, "add_aluwb");
        // CMP: SUB, no writeback, flags take ALUFlags=0100
        add(32'hE1510001, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0000_0, "cmp_fetch");
        add(32'hE1510001, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0000_0, "cmp_decode");
        add(32'hE1510001, 4'b0100, 20'b0_0_0_0_00_0_00_001_0_00_0000_0, "cmp_execr");
        add(32'hE1510001, 4'b1010, 20'b0_0_0_0_00_0_00_000_0_00_0100_0, "cmp_aluwb");
        // BEQ taken
        add(32'h0A000002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "beq_fetch");
        add(32'h0A000002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_0, "beq_decode");
        add(32'h0A000002, 4'b1010, 20'b1_0_0_0_10_0_01_000_0_01_0100_0, "beq_branch");
        // BNE not taken, same cycle count
        add(32'h1A000002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "bne_fetch");
        add(32'h1A000002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_0, "bne_decode");
        add(32'h1A000002, 4'b1010, 20'b0_0_0_0_10_0_01_000_0_01_0100_0, "bne_branch");
        // ADDNE with Z=1: full 4 cycles, write suppressed
        add(32'h10812002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "addne_fetch");
        add(32'h10812002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_0, "addne_decode");
        add(32'h10812002, 4'b1111, 20'b0_0_0_0_00_0_00_000_0_00_0100_0, "addne_execr");
        add(32'h10812002, 4'b1010, 20'b0_0_0_0_00_0_00_000_0_00_0100_0, "addne_aluwb");
        // LDR: 5 cycles
        add(32'hE5904004, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "ldr_fetch");
        add(32'hE5904004, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_0, "ldr_decode");
        add(32'hE5904004, 4'b1010, 20'b0_0_0_0_00_0_01_000_0_00_0100_0, "ldr_memadr");
        add(32'hE5904004, 4'b1010, 20'b0_1_0_0_00_0_00_000_0_00_0100_0, "ldr_memrd");
        add(32'hE5904004, 4'b1010, 20'b0_0_0_0_01_0_00_000_1_00_0100_0, "ldr_memwb");
        // STR: 4 cycles
        add(32'hE5804004, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "str_fetch");
        add(32'hE5804004, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_0, "str_decode");
        add(32'hE5804004, 4'b1010, 20'b0_0_0_0_00_0_01_000_0_00_0100_0, "str_memadr");
        add(32'hE5804004, 4'b1010, 20'b0_1_1_0_00_0_00_000_0_10_0100_0, "str_memwr");
        // EOR on the narrow ALU: illegal, 2 cycles
        add(32'hE0212002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "eor2_fetch");
        add(32'hE0212002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_1, "eor2_decode");
        // ADDS: all four flags written
        add(32'hE0912002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0100_0, "adds_fetch");
        add(32'hE0912002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0100_0, "adds_decode");
        add(32'hE0912002, 4'b0011, 20'b0_0_0_0_00_0_00_000_0_00_0100_0, "adds_execr");
        add(32'hE0912002, 4'b1010, 20'b0_0_0_0_00_0_00_000_1_00_0011_0, "adds_aluwb");
        // ANDS immediate: NZ written, CV held
        add(32'hE2110000, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0011_0, "ands_fetch");
        add(32'hE2110000, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0011_0, "ands_decode");
        add(32'hE2110000, 4'b1100, 20'b0_0_0_0_00_0_01_010_0_00_0011_0, "ands_execi");
        add(32'hE2110000, 4'b1010, 20'b0_0_0_0_00_0_00_000_1_00_1111_0, "ands_aluwb");
        // Flags 1111: LE true, GT false, cond 1111 false
        add(32'hDA000002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_1111_0, "ble_fetch");
        add(32'hDA000002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_1111_0, "ble_decode");
        add(32'hDA000002, 4'b1010, 20'b1_0_0_0_10_0_01_000_0_01_1111_0, "ble_branch");
        add(32'hCA000002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_1111_0, "bgt_fetch");
        add(32'hCA000002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_1111_0, "bgt_decode");
        add(32'hCA000002, 4'b1010, 20'b0_0_0_0_10_0_01_000_0_01_1111_0, "bgt_branch");
        add(32'hFA000002, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_1111_0, "bnv_fetch");
        add(32'hFA000002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_1111_0, "bnv_decode");
        add(32'hFA000002, 4'b1010, 20'b0_0_0_0_10_0_01_000_0_01_1111_0, "bnv_branch");

        // Wide ALU: EOR and MOV execute (fetch row is checked by hand after reset)
        add3(32'hE0212002, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0000_0, "eor3_decode");
        add3(32'hE0212002, 4'b1111, 20'b0_0_0_0_00_0_00_100_0_00_0000_0, "eor3_execr");
        add3(32'hE0212002, 4'b1010, 20'b0_0_0_0_00_0_00_000_1_00_0000_0, "eor3_aluwb");
        add3(32'hE1A02001, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_0000_0, "mov3_fetch");
        add3(32'hE1A02001, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_0000_0, "mov3_decode");
        add3(32'hE1A02001, 4'b1111, 20'b0_0_0_0_00_0_00_101_0_00_0000_0, "mov3_execr");
        add3(32'hE1A02001, 4'b1010, 20'b0_0_0_0_00_0_00_000_1_00_0000_0, "mov3_aluwb");

        // Reset held: enables low, flags clear
        @(negedge clk);
        #1;
        check("reset_d2", act2(), RST_VEC);
        check("reset_d3", act3(), RST_VEC);
        rst_n = 1'b1;

        foreach (vecs[i]) step_row(vecs[i], 1'b0);

        // LDR interrupted by reset in MEMRD
        step_row('{32'hE5904004, 4'b1010, 20'b1_0_0_1_10_1_10_000_0_00_1111_0, "ldrr_fetch"}, 1'b0);
        check("ldrr_immsrc", {18'b0, imm2}, 20'd1);
        step_row('{32'hE5904004, 4'b1010, 20'b0_0_0_0_10_1_10_000_0_00_1111_0, "ldrr_decode"}, 1'b0);
        step_row('{32'hE5904004, 4'b1010, 20'b0_0_0_0_00_0_01_000_0_00_1111_0, "ldrr_memadr"}, 1'b0);
        #1;
        check("ldrr_memrd", act2(), 20'b0_1_0_0_00_0_00_000_0_00_1111_0);
        #1 rst_n = 1'b0;
        #1;
        check("ldrr_async_reset", act2(), RST_VEC);
        @(negedge clk);
        #1;
        check("ldrr_reset_held", act2(), RST_VEC);
        rst_n = 1'b1;
        instr = 32'hE0212002;
        alu_flags = 4'b1010;
        #1;
        check("rst_release_fetch_d2", act2(), 20'b1_0_0_1_10_1_10_000_0_00_0000_0);
        check("rst_release_fetch_d3", act3(), 20'b1_0_0_1_10_1_10_000_0_00_0000_0);
        @(negedge clk);

        foreach (vecs3[i]) step_row(vecs3[i], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control unit for the ARM-subset processor. It sequences each instruction through a Moore state machine (fetch, decode, execute, memory, writeback). It holds the NZCV flag register and evaluates all fifteen condition codes. It drives the shared-memory, single-ALU datapath, and the ALU control width is a parameter that enables an extended opcode set.

## Interface
- `ALU_CTRL_W`, 2: ALUControl width.
  - 2 gives ADD/SUB/AND/ORR.
  - 3 also gives EOR and MOV.
- `COND_EN`, 1: condition evaluation.
  - 0 treats every instruction as AL (cond field ignored).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Instr` input 32: instruction register contents; stable from DECODE until the next FETCH.
- `ALUFlags` input 4: N,Z,C,V from the ALU, combinational in the current cycle.
- `PCWrite` output 1: PC load enable.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = ALU result register.
- `MemWrite` output 1: data memory write.
- `IRWrite` output 1: instruction register load.
- `ResultSrc` output 2: result select. 00 = ALUOut, 01 = Data, 10 = ALU result.
- `ALUSrcA` output 1: ALU A select. 0 = RD1, 1 = PC.
- `ALUSrcB` output 2: ALU B select. 00 = RD2/shifted, 01 = ExtImm, 10 = constant 4.
- `ALUControl` output ALU_CTRL_W: ALU operation. 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 pass-B.
- `ImmSrc` output 2: immediate format. 00 = 8-bit DP, 01 = 12-bit mem, 10 = 24-bit branch; equals `Instr[27:26]`.
- `RegWrite` output 1: register file write enable.
- `RegSrc` output 2:
  - bit0 = branch (RA1 = R15).
  - bit1 = store (RA2 = Rd).
- `Flags` output 4: current NZCV register.
- `Illegal` output 1: one-cycle pulse in DECODE for an unsupported op/opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- All outputs are decoded from the state (Moore), except that the write enables are gated by CondEx.
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (produces PC+8).
  - Registers CondEx.
  - Next state by op field:
    - Op=01 → MEMADR.
    - Op=00 with I=0 → EXECR.
    - Op=00 with I=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11 or an illegal opcode → pulse Illegal and go to FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next is MEMRD if L (`Instr[20]`) is 1, otherwise MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next: FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx, RegSrc=10. Next: FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd. Next: ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUControl from cmd. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx and not CMP. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, RegSrc=01, PCWrite=CondEx. Next: FETCH.
- Opcode decode from `Instr[24:21]`:
  - 0100 ADD.
  - 0010 SUB.
  - 0000 AND.
  - 1100 ORR.
  - 1010 CMP: SUB with S forced to 1, no writeback.
  - When ALU_CTRL_W=3 only: 0001 EOR and 1101 MOV (pass-B).
  - Anything else is illegal.
- Condition codes (`Instr[31:28]`), full ARM set:
  - EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V.
  - HI = C&~Z; LS = ~C|Z.
  - GE = N==V; LT = N!=V.
  - GT = ~Z&(N==V); LE = Z|(N!=V).
  - AL = 1.
  - 1111 evaluates as false.
- Flag update: at the end of EXECR/EXECI when CondEx is 1 and (S=`Instr[20]` or CMP).
  - NZ are always written.
  - CV are written only for ADD/SUB/CMP.
  - For logical ops and MOV, C and V hold.
- CondEx is sampled once in DECODE from the flags before the update. A flag write by the executing instruction never affects its own CondEx.

## Timing
- Latency in cycles including FETCH: DP 4, STR 4, LDR 5, B 3, illegal 2.
- CondEx=0 never changes the cycle count; only the writes are suppressed.
- ALUFlags are sampled on the rising edge that leaves EXECR/EXECI. Flags are valid from the following cycle.
- Reset (rst_n low, asynchronous):
  - state = FETCH, Flags = 0000, CondEx = 0, Illegal = 0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while rst_n is low.
- Reset mid-instruction aborts immediately, with no partial register or memory write. After release, the first edge performs FETCH.
- Instr changes outside the DECODE→FETCH window are ignored by the FSM.

## Test plan
- Reset then release: Flags=0000 and all enables are 0 during reset. Cycle 1 after release shows IRWrite=1 and PCWrite=1.
- 0xE0812002 (ADD R2,R1,R2):
  - States are FETCH, DECODE, EXECR, ALUWB.
  - ALUControl=0 in EXECR.
  - RegWrite=1 only in ALUWB.
  - Flags are unchanged.
- 0xE1510001 (CMP) with ALUFlags=0100:
  - RegWrite stays 0.
  - Flags=0100 afterwards.
  - Then 0x0A000002 (BEQ) gives PCWrite=1 in BRANCH (3 cycles); 0x1A000002 (BNE) gives PCWrite=0.
- 0xE5904004 (LDR) runs 5 cycles with AdrSrc=1 in MEMRD and RegWrite=1 in MEMWB. 0xE5804004 (STR) runs 4 cycles with MemWrite=1 and RegSrc=10 in MEMWR.
- With ALU_CTRL_W=2, 0xE0212002 (EOR) pulses Illegal in DECODE, then FETCH; no writes. With ALU_CTRL_W=3 it executes with ALUControl=4.
- rst_n pulsed low during MEMRD of an LDR:
  - The FSM returns to FETCH asynchronously.
  - RegWrite is never asserted.
  - Flags=0000.
